key_schedule_ctrl: RTL and testbench

- Sequential AES-128 key-expansion controller that sits directly upstream of the KeyGeneration round-key stage.
- Captures a 128-bit cipher key, then drives KeyGeneration's prevKey and rc inputs one round per cycle, feeding each nextKey back as the following round's prevKey.
- Stores all 11 round keys (0..10) in an internal register file.
- Serves them to the cipher datapath through a registered read port.

---
 rtl/key_schedule_ctrl.sv | 151 +++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// AES-128 key expansion: capture key, derive one round key per cycle, serve all 11 from a register file.
// Latency: ready 10 edges after the accepting edge; rk_data/rk_valid one edge after rk_rd. No backpressure: start ignored while busy.
module key_generation #(
    parameter int RCW = 4
) (
    input  logic [127:0]   prev_key,
    input  logic [RCW-1:0] rc,
    input  logic           en,
    output logic [127:0]   next_key
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] b;
        r = 8'h01;
        b = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, b);
            b = gmul(b, b);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]  rcon;
    logic [31:0] w0, w1, w2, w3, tmp, n0, n1, n2, n3;

    always_comb begin
        rcon = 8'h00;
        case (rc)
            RCW'(1):  rcon = 8'h01;
            RCW'(2):  rcon = 8'h02;
            RCW'(3):  rcon = 8'h04;
            RCW'(4):  rcon = 8'h08;
            RCW'(5):  rcon = 8'h10;
            RCW'(6):  rcon = 8'h20;
            RCW'(7):  rcon = 8'h40;
            RCW'(8):  rcon = 8'h80;
            RCW'(9):  rcon = 8'h1b;
            RCW'(10): rcon = 8'h36;
            default:  rcon = 8'h00;
        endcase
    end

    assign w0 = prev_key[127:96];
    assign w1 = prev_key[95:64];
    assign w2 = prev_key[63:32];
    assign w3 = prev_key[31:0];

    // SubWord(RotWord(w3)) xor rcon in the top byte
    assign tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
    assign n0  = w0 ^ tmp;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;

    assign next_key = en ? {n0, n1, n2, n3} : prev_key;
endmodule

module key_schedule_ctrl #(
    parameter int NR = 10,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    input  logic [127:0]  key_in,
    output logic          busy,
    output logic          ready,
    input  logic [AW-1:0] rk_addr,
    input  logic          rk_rd,
    output logic [127:0]  rk_data,
    output logic          rk_valid
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    localparam logic [AW-1:0] LAST = AW'(NR);

    state_t        state;
    logic [AW-1:0] cnt;
    logic [127:0]  wkey;
    logic [127:0]  slots [0:NR];
    logic [127:0]  next_key;
    logic          accept;

    key_generation #(.RCW(AW)) u_keygen (
        .prev_key (wkey),
        .rc       (cnt),
        .en       (busy),
        .next_key (next_key)
    );

    assign accept = start && (state != EXPAND);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            cnt      <= '0;
            wkey     <= '0;
            busy     <= 1'b0;
            ready    <= 1'b0;
            rk_data  <= '0;
            rk_valid <= 1'b0;
            for (int i = 0; i <= NR; i++) slots[i] <= '0;
        end else begin
            // Read uses the pre-edge contents, so a read racing a restart sees the old keys.
            rk_valid <= rk_rd && ready;
            if (rk_rd && ready) rk_data <= (rk_addr <= LAST) ? slots[rk_addr] : '0;

            if (accept) begin
                slots[0] <= key_in;
                wkey     <= key_in;
                cnt      <= AW'(1);
                busy     <= 1'b1;
                ready    <= 1'b0;
                state    <= EXPAND;
            end else if (state == EXPAND) begin
                slots[cnt] <= next_key;
                wkey       <= next_key;
                if (cnt == LAST) begin
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= READY;
                end else begin
                    cnt <= cnt + AW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Random and directed stimulus against a key-level model of the expansion controller.
module tb_key_schedule_ctrl;
    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy, ready, rk_valid;
    logic [3:0]   rk_addr = '0;
    logic         rk_rd = 1'b0;
    logic [127:0] rk_data;

    key_schedule_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .key_in(key_in),
        .busy(busy), .ready(ready), .rk_addr(rk_addr), .rk_rd(rk_rd),
        .rk_data(rk_data), .rk_valid(rk_valid)
    );

    always #5 CLK = ~CLK;

    localparam logic [127:0] FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FK1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQK  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    logic [7:0] sb [256];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sb[a] = s ^ 8'h63;
        end
    endtask

    // Textbook word-array expansion, then pick the requested round.
    function automatic logic [127:0] rkey(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Model: remembers only the cipher key and how many expansion cycles remain.
    logic         m_busy, m_ready, m_valid;
    logic [127:0] m_data, m_key;
    int           m_left;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_busy <= 1'b0; m_ready <= 1'b0; m_valid <= 1'b0; m_data <= '0; m_left <= 0;
        end else begin
            m_valid <= rk_rd && m_ready;
            if (rk_rd && m_ready) m_data <= (rk_addr <= 4'd10) ? rkey(m_key, int'(rk_addr)) : '0;
            if (start && !m_busy) begin
                m_key <= key_in; m_left <= 10; m_busy <= 1'b1; m_ready <= 1'b0;
            end else if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin m_busy <= 1'b0; m_ready <= 1'b1; end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("busy",     128'(busy),     128'(m_busy));
            chk("ready",    128'(ready),    128'(m_ready));
            chk("rk_valid", 128'(rk_valid), 128'(m_valid));
            chk("rk_data",  rk_data,        m_data);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Starts an expansion; optionally pulses start with another key at edge inj_at.
    task automatic expand(input logic [127:0] k, input int inj_at, output int bcnt, output int edges);
        start = 1'b1; key_in = k;
        tick();
        start = 1'b0;
        edges = 1;
        bcnt = busy ? 1 : 0;
        while (!ready && edges < 40) begin
            if (edges == inj_at) begin start = 1'b1; key_in = ~k; end
            tick();
            start = 1'b0;
            edges++;
            if (busy) bcnt++;
        end
    endtask

    task automatic rd(input string nm, input logic [3:0] a, input logic [127:0] exp);
        rk_rd = 1'b1; rk_addr = a;
        tick();
        rk_rd = 1'b0;
        chk({nm, "_valid"}, 128'(rk_valid), 128'd1);
        chk({nm, "_data"}, rk_data, exp);
    endtask

    int bc, ed;

    initial begin
        build_sbox();
        chk("model_k1", rkey(FIPS, 1), FK1);
        chk("model_seq10", rkey(SEQK, 10), SEQ10);
        tick(); tick();
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ready", 128'(ready), 128'd0);
        chk("rst_valid", 128'(rk_valid), 128'd0);
        chk("rst_data", rk_data, 128'd0);
        chk_en = 1'b1;
        RST_N = 1'b1;
        tick();

        rk_rd = 1'b1; rk_addr = 4'd0;
        tick();
        rk_rd = 1'b0;
        chk("idle_rd_valid", 128'(rk_valid), 128'd0);

        expand(FIPS, 0, bc, ed);
        chk("s1_busy_cycles", 128'(bc), 128'd10);
        chk("s1_ready_edges", 128'(ed), 128'd11);
        rd("s1_rd0", 4'd0, FIPS);
        rd("s1_rd1", 4'd1, FK1);
        rd("s1_rd10", 4'd10, FK10);
        rd("s2_rd15", 4'd15, 128'd0);

        expand(FIPS, 5, bc, ed);
        chk("s3_ready_edges", 128'(ed), 128'd11);
        rd("s3_rd10", 4'd10, FK10);

        start = 1'b1; key_in = FIPS;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 RST_N = 1'b0;
        #1;
        chk("s4_busy", 128'(busy), 128'd0);
        chk("s4_ready", 128'(ready), 128'd0);
        chk("s4_valid", 128'(rk_valid), 128'd0);
        tick();
        RST_N = 1'b1;
        tick();
        expand(FIPS, 0, bc, ed);
        chk("s4_busy_cycles", 128'(bc), 128'd10);
        chk("s4_ready_edges", 128'(ed), 128'd11);
        rd("s4_rd1", 4'd1, FK1);
        rd("s4_rd10", 4'd10, FK10);

        start = 1'b1; key_in = SEQK;
        tick();
        start = 1'b0;
        chk("s5_ready_drop", 128'(ready), 128'd0);
        ed = 1;
        while (!ready && ed < 40) begin tick(); ed++; end
        chk("s5_ready_edges", 128'(ed), 128'd11);
        rd("s5_rd10", 4'd10, SEQ10);

        start = 1'b1; key_in = FIPS; rk_rd = 1'b1; rk_addr = 4'd10;
        tick();
        start = 1'b0; rk_rd = 1'b0;
        chk("s6_valid", 128'(rk_valid), 128'd1);
        chk("s6_old_data", rk_data, SEQ10);
        ed = 1;
        while (!ready && ed < 40) begin tick(); ed++; end
        chk("s6_ready_edges", 128'(ed), 128'd11);
        rd("s6_rd10", 4'd10, FK10);

        for (int c = 0; c < 800; c++) begin
            rk_rd   = 1'($urandom_range(0, 1));
            rk_addr = 4'($urandom_range(0, 15));
            start   = ($urandom_range(0, 19) == 0);
            key_in  = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        start = 1'b0; rk_rd = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
